// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues one data-memory request per load/store,
// waits for the acknowledge, and formats the write-back bundle.
module mem_access_stage #(
    parameter int D_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_read,
    input  logic              ex_store,
    input  logic              ex_write_en,
    input  logic              ex_jmp_op,
    input  logic [2:0]        ex_funct3,
    input  logic [D_BITS-1:0] ex_result,
    input  logic [D_BITS-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [D_BITS-1:0] mem_addr,
    output logic [D_BITS-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [D_BITS-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_read,
    output logic              wb_write_en,
    output logic              wb_jmp_op,
    output logic [D_BITS-1:0] wb_data_in,
    output logic [D_BITS-1:0] wb_result,
    output logic [4:0]        wb_rd,
    output logic              misalign_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Undefined funct3 encodings fall through to word behaviour everywhere.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3)
            3'b000, 3'b100: r = 1'b0;
            3'b001, 3'b101: r = off[0];
            default:        r = (off != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] r;
        case (f3)
            3'b000, 3'b100: r = 4'b0001 << off;
            3'b001, 3'b101: r = off[1] ? 4'b1100 : 4'b0011;
            default:        r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [D_BITS-1:0] store_lanes(input logic [2:0] f3, input logic [D_BITS-1:0] d);
        logic [D_BITS-1:0] r;
        case (f3)
            3'b000, 3'b100: r = {(D_BITS/8){d[7:0]}};
            3'b001, 3'b101: r = {(D_BITS/16){d[15:0]}};
            default:        r = d;
        endcase
        return r;
    endfunction

    function automatic logic [D_BITS-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                      input logic [D_BITS-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [D_BITS-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  r = {{(D_BITS-8){b[7]}}, b};
            3'b001:  r = {{(D_BITS-16){h[15]}}, h};
            3'b100:  r = {{(D_BITS-8){1'b0}}, b};
            3'b101:  r = {{(D_BITS-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t            state_r, state_next_s;
    logic              killed_r;
    logic              lat_store_r, lat_we_r, lat_jmp_r;
    logic [2:0]        lat_f3_r;
    logic [D_BITS-1:0] lat_addr_r, lat_wdata_r;
    logic [4:0]        lat_rd_r;
    logic              misalign_err_r;
    logic              wb_valid_r, wb_read_r, wb_write_en_r, wb_jmp_op_r;
    logic [D_BITS-1:0] wb_data_in_r, wb_result_r;
    logic [4:0]        wb_rd_r;

    logic              accept_s, mem_op_s, mis_s, start_s, ack_s;
    logic              wb_valid_s, wb_read_s, wb_write_en_s, wb_jmp_op_s;
    logic [D_BITS-1:0] wb_data_in_s, wb_result_s;
    logic [4:0]        wb_rd_s;

    assign accept_s = ex_valid && (state_r == IDLE) && !flush;
    assign mem_op_s = ex_read || ex_store;
    assign mis_s    = accept_s && mem_op_s && is_misaligned(ex_funct3, ex_result[1:0]);
    assign start_s  = accept_s && mem_op_s && !mis_s;
    assign ack_s    = (state_r == WAIT_ACK) && mem_ack;

    // Next-state logic for the request handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = WAIT_ACK;
                else         state_next_s = IDLE;
            end
            WAIT_ACK: begin
                if (mem_ack) state_next_s = IDLE;
                else         state_next_s = WAIT_ACK;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Latched memory op; a flush during the wait only marks it killed so the bus handshake still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            killed_r    <= 1'b0;
            lat_store_r <= 1'b0;
            lat_we_r    <= 1'b0;
            lat_jmp_r   <= 1'b0;
            lat_f3_r    <= 3'b000;
            lat_addr_r  <= {D_BITS{1'b0}};
            lat_wdata_r <= {D_BITS{1'b0}};
            lat_rd_r    <= 5'd0;
        end else if (start_s) begin
            killed_r    <= 1'b0;
            lat_store_r <= ex_store;
            lat_we_r    <= ex_write_en;
            lat_jmp_r   <= ex_jmp_op;
            lat_f3_r    <= ex_funct3;
            lat_addr_r  <= ex_result;
            lat_wdata_r <= ex_store_data;
            lat_rd_r    <= ex_rd;
        end else if ((state_r == WAIT_ACK) && flush) begin
            killed_r    <= 1'b1;
        end
    end

    // Memory request outputs decode only from registered state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {D_BITS{1'b0}};
        mem_wdata = {D_BITS{1'b0}};
        mem_be    = 4'b0000;
        if (state_r == WAIT_ACK) begin
            mem_req   = 1'b1;
            mem_we    = lat_store_r;
            mem_addr  = {lat_addr_r[D_BITS-1:2], 2'b00};
            mem_wdata = store_lanes(lat_f3_r, lat_wdata_r);
            mem_be    = byte_en(lat_f3_r, lat_addr_r[1:0]);
        end else begin
            mem_req   = 1'b0;
        end
    end

    // Write-back bundle selection; anything other than an ALU accept or a live ack is a bubble.
    always_comb begin
        wb_valid_s    = 1'b0;
        wb_read_s     = 1'b0;
        wb_write_en_s = 1'b0;
        wb_jmp_op_s   = 1'b0;
        wb_data_in_s  = {D_BITS{1'b0}};
        wb_result_s   = {D_BITS{1'b0}};
        wb_rd_s       = 5'd0;
        if (accept_s && !mem_op_s) begin
            wb_valid_s    = 1'b1;
            wb_write_en_s = ex_write_en;
            wb_jmp_op_s   = ex_jmp_op;
            wb_result_s   = ex_result;
            wb_rd_s       = ex_rd;
        end else if (ack_s && !killed_r && !flush) begin
            wb_valid_s    = 1'b1;
            wb_read_s     = !lat_store_r;
            wb_write_en_s = lat_store_r ? 1'b0 : lat_we_r;
            wb_jmp_op_s   = lat_store_r ? 1'b0 : lat_jmp_r;
            wb_result_s   = lat_addr_r;
            wb_rd_s       = lat_rd_r;
            wb_data_in_s  = lat_store_r ? {D_BITS{1'b0}} : load_format(lat_f3_r, lat_addr_r[1:0], mem_rdata);
        end else begin
            wb_valid_s    = 1'b0;
        end
    end

    // Write-back and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_r     <= 1'b0;
            wb_read_r      <= 1'b0;
            wb_write_en_r  <= 1'b0;
            wb_jmp_op_r    <= 1'b0;
            wb_data_in_r   <= {D_BITS{1'b0}};
            wb_result_r    <= {D_BITS{1'b0}};
            wb_rd_r        <= 5'd0;
            misalign_err_r <= 1'b0;
        end else begin
            wb_valid_r     <= wb_valid_s;
            wb_read_r      <= wb_read_s;
            wb_write_en_r  <= wb_write_en_s;
            wb_jmp_op_r    <= wb_jmp_op_s;
            wb_data_in_r   <= wb_data_in_s;
            wb_result_r    <= wb_result_s;
            wb_rd_r        <= wb_rd_s;
            misalign_err_r <= mis_s;
        end
    end

    assign stall_out    = (state_r == WAIT_ACK);
    assign misalign_err = misalign_err_r;
    assign wb_valid     = wb_valid_r;
    assign wb_read      = wb_read_r;
    assign wb_write_en  = wb_write_en_r;
    assign wb_jmp_op    = wb_jmp_op_r;
    assign wb_data_in   = wb_data_in_r;
    assign wb_result    = wb_result_r;
    assign wb_rd        = wb_rd_r;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter D_BITS, default 32, SHALL set data and address width.
REQ-002 One clock; reset is asynchronous and active-high. Ports SHALL be:
- clk  in  1  clock, all state rises on posedge.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  upstream op valid.
- ex_read  in  1  load op.
- ex_store  in  1  store op.
- ex_write_en  in  1  op writes register file.
- ex_jmp_op  in  1  jump taken.
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_result  in  D_BITS  ALU result; byte address for load/store.
- ex_store_data  in  D_BITS  store source.
- ex_rd  in  5  destination register.
- flush  in  1  kill in-flight op.
- stall_out  out  1  block cannot accept; upstream holds.
- mem_req  out  1  data memory request.
- mem_we  out  1  request is write.
- mem_addr  out  D_BITS  word-aligned address.
- mem_wdata  out  D_BITS  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory completes request this cycle.
- mem_rdata  in  D_BITS  read word, valid with mem_ack.
- wb_valid, wb_read, wb_write_en, wb_jmp_op  out  1 each  registered write-back controls.
- wb_data_in  out  D_BITS  formatted load data.
- wb_result  out  D_BITS  ALU result pass-through.
- wb_rd  out  5  destination register.
- misalign_err  out  1  one-cycle misaligned-access pulse.

Function
REQ-003 FSM states SHALL be IDLE and WAIT_ACK; stall_out SHALL equal (state==WAIT_ACK), combinational.
REQ-004 Op accepted at posedge when ex_valid=1, stall_out=0, flush=0.
REQ-005 Accepted non-memory op: WB regs load at that edge (latency 1): wb_valid=1, wb_read=0, wb_write_en=ex_write_en, wb_jmp_op=ex_jmp_op, wb_result=ex_result, wb_rd=ex_rd, wb_data_in=0.
REQ-006 Accepted aligned load/store: op latched, state->WAIT_ACK, WB regs load bubble (all wb_* = 0).
REQ-007 In WAIT_ACK, mem_req=1, mem_we=latched store, mem_addr={addr[D_BITS-1:2],2'b00}, held stable until ack; in IDLE mem_req=0.
REQ-008 mem_be: W=1111; H=0011 (addr[1]=0) or 1100; B=0001<<addr[1:0]; loads same pattern.
REQ-009 mem_wdata: W as-is; H low half replicated ×2; B low byte replicated ×4.
REQ-010 Posedge with mem_ack=1 in WAIT_ACK: state->IDLE; WB regs load latched op; load => wb_read=1, wb_data_in=lane selected by addr[1:0], sign-extended (B,H) or zero-extended (BU,HU); store => wb_valid=1, wb_read=0, wb_write_en=0.
REQ-011 Minimum memory-op latency: ack sampled one edge after acceptance; WB valid after the ack edge.
REQ-012 Every other edge without accept or ack SHALL load a bubble (wb_read=wb_write_en=wb_jmp_op=wb_valid=0).
REQ-013 Misaligned access (H with addr[0]=1; W with addr[1:0]!=00): no memory request, state stays IDLE, bubble loaded, misalign_err=1 for exactly one cycle.
REQ-014 flush at an edge: op not accepted, bubble loaded. flush in WAIT_ACK SHALL NOT drop mem_req; handshake completes, op marked killed, ack edge loads bubble.
REQ-015 mem_ack in IDLE ignored; ex_valid while stall_out=1 ignored; flush beats simultaneous ex_valid.
REQ-016 Undefined funct3 SHALL be treated as W.

Reset
REQ-017 rst=1 SHALL immediately force state IDLE, killed flag 0, every output 0 (mem_req, stall_out, misalign_err, all wb_*), regardless of clock.
REQ-018 rst asserted in WAIT_ACK SHALL abandon the transaction; a later mem_ack is ignored.

Verification
REQ-019 ADD, result 0x0000_0010, write_en=1, rd=5 -> next edge wb_valid=1, wb_write_en=1, wb_result=0x10, wb_rd=5, wb_read=0.
REQ-020 LB addr 0x103, mem_rdata 0x80FF_1234, ack 2 cycles later -> mem_addr=0x100, mem_be=0001<<3=1000, stall_out high 2 cycles, wb_data_in=0xFFFF_FF80, wb_read=1.
REQ-021 SH addr 0x202, store_data 0x0000_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD; after ack wb_valid=1, wb_write_en=0.
REQ-022 LW addr 0x301 -> mem_req stays 0, misalign_err one cycle, wb_valid=0.
REQ-023 LHU addr 0x0, flush during WAIT_ACK, ack 0xFFFF_8001 -> mem_req held until ack, wb_valid=0, wb_read=0.
REQ-024 rst pulsed mid-WAIT_ACK -> all outputs 0 asynchronously; subsequent stray mem_ack produces no WB output.
